// File: rtl/ifu_fetch_pkg.sv
// -----------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared core definitions for the instruction fetch unit:
//   - fetch_state_e : FSM state encoding (IDLE, ADDR, DATA, OUT)
//   - RESP_OKAY     : read response code for a good transfer
//   - FAULT_INST    : instruction word reported alongside a fetch fault
//   - helpers       : alignment and response classification functions
// -----------------------------------------------------------------------------
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Wide enough for any practical instruction width; users slice to DATA_WIDTH.
  localparam logic [63:0] FAULT_INST = 64'd0;

  // Instructions are word aligned; any set low bit is a misaligned fetch.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
// Single-outstanding instruction fetch unit. Accepts a fetch address from the
// PC generator, issues one read on the memory address channel, captures the
// read data and presents it (with its address and a fault flag) to decode.
// Misaligned addresses never reach memory; they are reported as a fault
// directly. A flush discards whatever fetch is in flight or being held.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_valid, pc, pc_ready   fetch address handshake from PC generator
//   mem_arvalid, mem_araddr,
//   mem_arready              memory read-address channel
//   mem_rvalid, mem_rdata,
//   mem_rresp, mem_rready    memory read-data channel
//   inst_valid, inst,
//   inst_pc, inst_fault,
//   inst_ready               fetched instruction handshake to decode
//   flush                    redirect: drop in-flight or held fetch
// -----------------------------------------------------------------------------
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_valid,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_ready,
  output logic                  mem_arvalid,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  input  logic                  mem_arready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  output logic                  mem_rready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault,
  input  logic                  inst_ready,
  input  logic                  flush
);

  fetch_state_e state;
  logic         drop;       // in-flight response must be discarded
  logic         pc_accept;
  logic         pc_misaligned;

  // pc_ready is combinational so a new pc can be taken in the same OUT cycle
  // that decode consumes the current instruction (no bubble).
  always_comb begin
    pc_ready = 1'b0;
    if (rst) begin
      pc_ready = 1'b0;
    end else begin
      case (state)
        IDLE:    pc_ready = 1'b1;
        OUT:     pc_ready = inst_ready & ~flush;
        default: pc_ready = 1'b0;
      endcase
    end
  end

  assign pc_accept     = pc_valid & pc_ready;
  assign pc_misaligned = is_misaligned(pc[1:0]);

  // Fetch FSM together with all its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drop        <= 1'b0;
      mem_arvalid <= 1'b0;
      mem_araddr  <= '0;
      mem_rready  <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      inst_fault  <= 1'b0;
    end else if (pc_accept) begin
      // Only reachable from IDLE or from OUT while decode consumes.
      mem_araddr <= pc;
      inst_pc    <= pc;
      drop       <= 1'b0;
      mem_rready <= 1'b0;
      if (pc_misaligned) begin
        // Report the fault straight away; memory never sees this address.
        state       <= OUT;
        mem_arvalid <= 1'b0;
        inst_valid  <= 1'b1;
        inst        <= FAULT_INST[DATA_WIDTH-1:0];
        inst_fault  <= 1'b1;
      end else begin
        state       <= ADDR;
        mem_arvalid <= 1'b1;
        inst_valid  <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end

        ADDR: begin
          // The address request cannot be withdrawn once offered, so a flush
          // only marks the coming response for discard.
          if (flush) begin
            drop <= 1'b1;
          end
          if (mem_arready) begin
            state       <= DATA;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
          end
        end

        DATA: begin
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            drop       <= 1'b0;
            if (drop | flush) begin
              state <= IDLE;
            end else begin
              state      <= OUT;
              inst_valid <= 1'b1;
              inst       <= mem_rdata;
              inst_fault <= resp_is_error(mem_rresp);
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end

        OUT: begin
          // Consumption without a new pc, or any flush, returns to IDLE.
          if (flush | inst_ready) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          drop        <= 1'b0;
          mem_arvalid <= 1'b0;
          mem_rready  <= 1'b0;
          inst_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc;
  logic        pc_ready;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;
  logic        flush;

  int checks = 0;
  int errors = 0;

  ifu_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(mem_rready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_ready(inst_ready), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, pv;
    logic [31:0] pc;
    logic        ar, rv;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        ir, fl;
    logic        e_pcr, e_arv;
    logic [31:0] e_araddr;
    logic        e_rr, e_iv;
    logic [31:0] e_inst, e_ipc;
    logic        e_flt;
    logic        zchk;   // also compare instruction fields while inst_valid is low
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic r, input logic pv, input logic [31:0] p, input logic ar, input logic rv,
      input logic [31:0] rd, input logic [1:0] rr, input logic ir, input logic fl,
      input logic e_pcr, input logic e_arv, input logic [31:0] e_aa, input logic e_rr,
      input logic e_iv, input logic [31:0] e_in, input logic [31:0] e_ip, input logic e_f,
      input logic z);
    vec_t v;
    v.rst = r; v.pv = pv; v.pc = p; v.ar = ar; v.rv = rv; v.rdata = rd; v.rresp = rr;
    v.ir = ir; v.fl = fl; v.e_pcr = e_pcr; v.e_arv = e_arv; v.e_araddr = e_aa;
    v.e_rr = e_rr; v.e_iv = e_iv; v.e_inst = e_in; v.e_ipc = e_ip; v.e_flt = e_f; v.zchk = z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic pv, input logic [31:0] p, input logic ar,
                        input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                        input logic ir, input logic fl);
    rst = r; pc_valid = pv; pc = p; mem_arready = ar; mem_rvalid = rv;
    mem_rdata = rd; mem_rresp = rr; inst_ready = ir; flush = fl;
  endtask

  task automatic ctrl(input string tag, input logic pcr, input logic arv, input logic rr,
                      input logic iv);
    chk({tag, ".pc_ready"}, {31'd0, pc_ready}, {31'd0, pcr});
    chk({tag, ".arvalid"}, {31'd0, mem_arvalid}, {31'd0, arv});
    chk({tag, ".rready"}, {31'd0, mem_rready}, {31'd0, rr});
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, iv});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // reset and minimum latency fetch
    vecs.push_back(mk(1,1,32'h80000000,0,0,32'h0,2'b00,0,0, 0,0,32'h0,0,0,32'h0,32'h0,0,1));
    vecs.push_back(mk(0,1,32'h80000000,1,0,32'h0,2'b00,1,0, 1,0,32'h0,0,0,32'h0,32'h0,0,1));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,2'b00,1,0, 0,1,32'h80000000,0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h00000413,2'b00,1,0, 0,0,32'h0,1,0,32'h0,32'h0,0,0));
    // OUT: second pc accepted while decode consumes
    vecs.push_back(mk(0,1,32'h80000004,0,0,32'h0,2'b00,1,0, 1,0,32'h0,0,1,32'h00000413,32'h80000000,0,0));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,2'b00,1,0, 0,1,32'h80000004,0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h00100093,2'b00,1,0, 0,0,32'h0,1,0,32'h0,32'h0,0,0));
    // OUT: misaligned pc accepted, fault reported next cycle with no request
    vecs.push_back(mk(0,1,32'h80000002,0,0,32'h0,2'b00,1,0, 1,0,32'h0,0,1,32'h00100093,32'h80000004,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,2'b00,1,0, 1,0,32'h0,0,1,32'h0,32'h80000002,1,0));
    // IDLE: flush has no effect, pc accepted
    vecs.push_back(mk(0,1,32'h80000008,0,0,32'h0,2'b00,0,1, 1,0,32'h0,0,0,32'h0,32'h0,0,0));
    // ADDR: stale rvalid ignored, wait for arready
    vecs.push_back(mk(0,0,32'h0,0,1,32'h0,2'b00,0,0, 0,1,32'h80000008,0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,2'b00,0,0, 0,1,32'h80000008,0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,2'b00,0,0, 0,0,32'h0,1,0,32'h0,32'h0,0,0));
    // error response
    vecs.push_back(mk(0,0,32'h0,0,1,32'hDEADBEEF,2'b10,0,0, 0,0,32'h0,1,0,32'h0,32'h0,0,0));
    // decode stalls 4 cycles: outputs stable, pc not accepted
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,1,32'h8000000C,0,0,32'h0,2'b00,0,0, 0,0,32'h0,0,1,32'hDEADBEEF,32'h80000008,1,0));
    // flush in OUT: no pc accepted, inst_valid drops next cycle
    vecs.push_back(mk(0,1,32'h8000000C,0,0,32'h0,2'b00,1,1, 0,0,32'h0,0,1,32'hDEADBEEF,32'h80000008,1,0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,2'b00,0,0, 1,0,32'h0,0,0,32'h0,32'h0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      set_in(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].ar, vecs[i].rv,
             vecs[i].rdata, vecs[i].rresp, vecs[i].ir, vecs[i].fl);
      #1;
      ctrl(t, vecs[i].e_pcr, vecs[i].e_arv, vecs[i].e_rr, vecs[i].e_iv);
      if (vecs[i].e_arv)
        chk({t, ".araddr"}, mem_araddr, vecs[i].e_araddr);
      if (vecs[i].e_iv || vecs[i].zchk) begin
        chk({t, ".inst"}, inst, vecs[i].e_inst);
        chk({t, ".inst_pc"}, inst_pc, vecs[i].e_ipc);
        chk({t, ".inst_fault"}, {31'd0, inst_fault}, {31'd0, vecs[i].e_flt});
      end
      step();
    end

    // flush in 2nd ADDR cycle, arready delayed 3 cycles
    set_in(0, 1, 32'h80000010, 0, 0, 32'h0, 2'b00, 1, 0); #1;
    ctrl("fa.accept", 1, 0, 0, 0);
    step();
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, 32'h0, (c == 3), 0, 32'h0, 2'b00, 1, (c == 1)); #1;
      ctrl($sformatf("fa.addr%0d", c), 0, 1, 0, 0);
      chk($sformatf("fa.araddr%0d", c), mem_araddr, 32'h80000010);
      step();
    end
    set_in(0, 0, 32'h0, 0, 1, 32'h11111111, 2'b00, 1, 0); #1;
    ctrl("fa.data", 0, 0, 1, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 1, 0); #1;
      ctrl($sformatf("fa.after%0d", c), 1, 0, 0, 0);
      step();
    end

    // flush in the same cycle as rvalid
    set_in(0, 1, 32'h80000020, 0, 0, 32'h0, 2'b00, 1, 0); step();
    set_in(0, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 0); step();
    set_in(0, 0, 32'h0, 0, 1, 32'h33333333, 2'b00, 1, 1); #1;
    ctrl("fd.data", 0, 0, 1, 0);
    step();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 1, 0); #1;
    ctrl("fd.after", 1, 0, 0, 0);

    // flush in DATA before the response arrives
    set_in(0, 1, 32'h80000030, 0, 0, 32'h0, 2'b00, 1, 0); step();
    set_in(0, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 0); step();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 1, 1); step();
    set_in(0, 0, 32'h0, 0, 1, 32'h44444444, 2'b00, 1, 0); #1;
    ctrl("fe.data", 0, 0, 1, 0);
    step();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 1, 0); #1;
    ctrl("fe.after", 1, 0, 0, 0);

    // reset in DATA, stale rvalid afterwards
    set_in(0, 1, 32'h80000040, 0, 0, 32'h0, 2'b00, 1, 0); step();
    set_in(0, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 0); step();
    set_in(1, 0, 32'h0, 0, 0, 32'h0, 2'b00, 1, 0); #1;
    ctrl("rd.inrst", 0, 0, 1, 0);
    step();
    set_in(0, 0, 32'h0, 0, 1, 32'h22222222, 2'b00, 1, 0); #1;
    ctrl("rd.post", 1, 0, 0, 0);
    chk("rd.inst", inst, 32'h0);
    chk("rd.inst_pc", inst_pc, 32'h0);
    chk("rd.inst_fault", {31'd0, inst_fault}, 32'h0);
    step();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 1, 0); #1;
    ctrl("rd.stale", 1, 0, 0, 0);
    chk("rd.stale_inst", inst, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction and data width.
REQ-002 Parameter ADDR_WIDTH, default 32, fetch address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pc_valid  input  1  upstream PC generator offers a fetch address.
REQ-006 pc  input  ADDR_WIDTH  fetch address.
REQ-007 pc_ready  output  1  block accepts pc this cycle; upstream holds PC while low.
REQ-008 mem_arvalid  output  1  memory read-address valid.
REQ-009 mem_araddr  output  ADDR_WIDTH  memory read address.
REQ-010 mem_arready  input  1  memory accepts address.
REQ-011 mem_rvalid  input  1  memory read data valid.
REQ-012 mem_rdata  input  DATA_WIDTH  read data.
REQ-013 mem_rresp  input  2  read response; 2'b00 = OKAY, anything else = error.
REQ-014 mem_rready  output  1  block accepts read data.
REQ-015 inst_valid  output  1  fetched instruction available to decode.
REQ-016 inst  output  DATA_WIDTH  instruction word.
REQ-017 inst_pc  output  ADDR_WIDTH  address that instruction was fetched from.
REQ-018 inst_fault  output  1  fetch fault: misaligned or error response.
REQ-019 inst_ready  input  1  decode consumes instruction.
REQ-020 flush  input  1  redirect; discard any in-flight or held fetch.

Function
REQ-021 The FSM SHALL have four states: IDLE, ADDR, DATA, OUT.
REQ-022 IDLE: pc_ready=1; on pc_valid, the block SHALL latch pc and go to ADDR, or to OUT with inst_fault=1 and inst=0 if pc[1:0]!=0. No memory request is issued for a misaligned pc.
REQ-023 ADDR: mem_arvalid=1 and mem_araddr=latched pc, both held stable until mem_arready; on mem_arready the block SHALL go to DATA.
REQ-024 DATA: mem_rready=1; on mem_rvalid the block SHALL latch mem_rdata, set inst_fault=(mem_rresp!=0), and go to OUT.
REQ-025 OUT: inst_valid=1; inst, inst_pc and inst_fault SHALL be held stable until inst_ready.
REQ-026 pc_ready SHALL be 1 in IDLE and in OUT when inst_ready=1 and flush=0. An accepted pc in OUT SHALL start the next fetch in the following cycle, with no bubble state.
REQ-027 Outside these cases, pc_ready, mem_arvalid, mem_rready and inst_valid SHALL be 0.
REQ-028 Minimum latency: pc accepted at cycle T; mem_arvalid at T+1; with mem_arready at T+1 and mem_rvalid at T+2, inst_valid SHALL be 1 at T+3.
REQ-029 flush in ADDR: mem_arvalid SHALL stay asserted until the handshake, and a drop flag SHALL be set; the subsequent response SHALL be accepted, discarded, and the block returns to IDLE without inst_valid.
REQ-030 flush in DATA: set the drop flag; the response SHALL be consumed and discarded, then return to IDLE. flush in the same cycle as mem_rvalid SHALL also discard.
REQ-031 flush in OUT: inst_valid SHALL drop in the next cycle, the state returns to IDLE, and no pc is accepted that cycle.
REQ-032 flush in IDLE SHALL have no effect; a pc_valid in the same cycle SHALL be accepted.
REQ-033 The block SHALL ignore mem_rvalid outside DATA and mem_arready outside ADDR.
REQ-034 At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-035 With rst=1 at a clock edge, the block SHALL enter IDLE; clear the drop flag; and drive inst, inst_pc, inst_fault and all valid outputs to 0. pc_ready SHALL be 0 while rst=1.
REQ-036 Reset mid-transaction SHALL abandon the transaction; memory SHALL be reset in the same cycle.

Structure
REQ-037 The state encoding, RESP_OKAY=2'b00 and the fault instruction value 0 SHALL live in the shared core package.
REQ-038 No sub-module is required; the FSM and its output registers SHALL be flat in ifu_fetch.

Verification
REQ-039 After reset, pc=0x80000000 with pc_valid, memory ready with zero wait: araddr=0x80000000 at T+1; inst=0x00000413 with inst_pc=0x80000000 and inst_valid at T+3.
REQ-040 Back-to-back fetches 0x80000000/0x80000004 with inst_ready=1: the second pc is accepted in the OUT cycle, and the second mem_arvalid follows the next cycle.
REQ-041 pc=0x80000002: no mem_arvalid; inst_valid=1 at T+1 with inst_fault=1 and inst=0.
REQ-042 mem_arready delayed 3 cycles with flush in the 2nd ADDR cycle: araddr is stable throughout, the response is discarded, and there is no inst_valid.
REQ-043 mem_rresp=2'b10: inst_fault=1, inst=rdata; inst_ready low for 4 cycles keeps the outputs stable.
REQ-044 rst asserted in DATA: the next cycle shows IDLE, all outputs 0, and a stale mem_rvalid is ignored.
